// File: rtl/fpu_stim_driver.sv
// FPU stimulus sequencer: drives corner-case or LFSR vectors into an FPU,
// samples result and flags after the pipeline latency, and emits records.
module fpu_stim_driver #(
   parameter int FPU_LATENCY = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int NUM_RAND    = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mode,
   input  logic [31:0] seed,
   output logic        busy,
   output logic        done,
   output logic [31:0] opa,
   output logic [31:0] opb,
   output logic [2:0]  fpu_op,
   output logic [1:0]  rmode,
   input  logic [31:0] fpu_out,
   input  logic        inf,
   input  logic        snan,
   input  logic        qnan,
   input  logic        ine,
   input  logic        overflow,
   input  logic        underflow,
   input  logic        zero,
   input  logic        div_by_zero,
   output logic        rec_valid,
   input  logic        rec_ready,
   output logic [31:0] rec_opa,
   output logic [31:0] rec_opb,
   output logic [2:0]  rec_op,
   output logic [31:0] rec_out,
   output logic [7:0]  rec_flags,
   output logic [15:0] vec_count
);

   localparam logic [31:0] NEUTRAL    = 32'h3F80_0000;
   localparam logic [31:0] TAPS       = 32'h8020_0003;
   localparam logic [3:0]  GAP_LOAD   = 4'(GAP_CYCLES - 1);
   localparam logic [3:0]  LAT_LOAD   = 4'(FPU_LATENCY - 1);
   localparam logic [15:0] LAST_RAND  = 16'(NUM_RAND - 1);
   localparam logic [15:0] LAST_SWEEP = 16'd255;

   typedef enum logic [2:0] {
      S_IDLE, S_GAP, S_APPLY, S_WAIT, S_PRESENT, S_DONE
   } state_t;

   state_t      state, state_nx;
   logic        run_mode;
   logic [31:0] lfsr, lfsr_nx;
   logic [15:0] idx;
   logic [3:0]  cnt;
   logic [31:0] vec_a, vec_b;
   logic [2:0]  vec_op;
   logic        accept, last;

   function automatic logic [31:0] corner(input logic [2:0] i);
      logic [31:0] v;
      unique case (i)
         3'd0:    v = 32'h0000_0000;
         3'd1:    v = 32'h3F80_0000;
         3'd2:    v = 32'h7F80_0000;
         3'd3:    v = 32'h7F7F_FFFF;
         3'd4:    v = 32'h0000_0001;
         3'd5:    v = 32'hBF80_0000;
         3'd6:    v = 32'hFF80_0000;
         default: v = 32'h7FC0_0000;
      endcase
      return v;
   endfunction

   assign rmode     = 2'b00;
   assign rec_valid = (state == S_PRESENT);
   assign accept    = rec_valid && rec_ready;
   assign last      = (idx == (run_mode ? LAST_RAND : LAST_SWEEP));
   assign lfsr_nx   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);

   // Current test vector from the sweep index or the LFSR state
   always_comb begin
      vec_a  = corner(idx[5:3]);
      vec_b  = corner(idx[2:0]);
      vec_op = {1'b0, idx[7:6]};
      if (run_mode) begin
         vec_a  = lfsr;
         vec_b  = {lfsr[15:0], lfsr[31:16]};
         vec_op = {1'b0, lfsr[1:0]};
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next state and FPU pin drive; neutral vector outside APPLY/WAIT
   always_comb begin
      state_nx = state;
      opa      = NEUTRAL;
      opb      = NEUTRAL;
      fpu_op   = 3'b000;
      unique case (state)
         S_IDLE:    if (start) state_nx = S_GAP;
         S_GAP:     if (cnt == '0) state_nx = S_APPLY;
         S_APPLY: begin
            opa      = vec_a;
            opb      = vec_b;
            fpu_op   = vec_op;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            opa    = vec_a;
            opb    = vec_b;
            fpu_op = vec_op;
            if (cnt == '0) state_nx = S_PRESENT;
         end
         S_PRESENT: if (accept) state_nx = last ? S_DONE : S_GAP;
         S_DONE:    state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // Run control, counters, LFSR and record capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_mode  <= 1'b0;
         lfsr      <= 32'd1;
         idx       <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rec_opa   <= '0;
         rec_opb   <= '0;
         rec_op    <= '0;
         rec_out   <= '0;
         rec_flags <= '0;
         vec_count <= '0;
      end else begin
         unique case (state)
            S_IDLE: if (start) begin
               run_mode  <= mode;
               lfsr      <= (seed == '0) ? 32'd1 : seed;
               idx       <= '0;
               vec_count <= '0;
               done      <= 1'b0;
               busy      <= 1'b1;
               cnt       <= GAP_LOAD;
            end
            S_GAP: begin
               if (cnt == '0) lfsr <= lfsr_nx;
               else           cnt  <= cnt - 4'd1;
            end
            S_APPLY: cnt <= LAT_LOAD;
            S_WAIT: begin
               if (cnt == '0) begin
                  rec_opa   <= vec_a;
                  rec_opb   <= vec_b;
                  rec_op    <= vec_op;
                  rec_out   <= fpu_out;
                  rec_flags <= {div_by_zero, zero, underflow, overflow,
                                ine, qnan, snan, inf};
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_PRESENT: if (accept) begin
               if (vec_count != 16'hFFFF) vec_count <= vec_count + 16'd1;
               if (last) begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end else begin
                  idx <= idx + 16'd1;
                  cnt <= GAP_LOAD;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_stim_driver.sv
// Bench for fpu_stim_driver: pipelined FPU stand-in, reference vector model,
// sweep/random/backpressure/reset-mid-run scenarios.
module tb_fpu_stim_driver;

   localparam int LAT = 4;
   localparam logic [31:0] NEUTRAL = 32'h3F80_0000;
   localparam logic [31:0] TBL [8] = '{
      32'h0000_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h7F7F_FFFF,
      32'h0000_0001, 32'hBF80_0000, 32'hFF80_0000, 32'h7FC0_0000};

   logic        clk = 1'b0;
   logic        rst_n, start, mode, rec_ready;
   logic [31:0] seed;
   logic        busy, done, rec_valid;
   logic [31:0] opa, opb, fpu_out, rec_opa, rec_opb, rec_out;
   logic [2:0]  fpu_op, rec_op;
   logic [1:0]  rmode;
   logic [7:0]  rec_flags;
   logic [15:0] vec_count;
   logic        inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero;

   logic [39:0] pipe [LAT] = '{default: '0};

   int tests = 0;
   int fails = 0;
   bit          run_mode;
   logic [31:0] exp_lfsr;
   logic [31:0] got_opa, got_opb, got_out;
   logic [2:0]  got_op;
   logic [7:0]  got_flags;

   fpu_stim_driver #(.FPU_LATENCY(LAT), .GAP_CYCLES(2), .NUM_RAND(64)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
      .busy(busy), .done(done), .opa(opa), .opb(opb), .fpu_op(fpu_op),
      .rmode(rmode), .fpu_out(fpu_out), .inf(inf), .snan(snan),
      .qnan(qnan), .ine(ine), .overflow(overflow),
      .underflow(underflow), .zero(zero), .div_by_zero(div_by_zero),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_opa(rec_opa),
      .rec_opb(rec_opb), .rec_op(rec_op), .rec_out(rec_out),
      .rec_flags(rec_flags), .vec_count(vec_count));

   always #5 clk = ~clk;

   function automatic bit is_zero(input logic [31:0] x);
      return x[30:0] == 31'd0;
   endfunction
   function automatic bit is_inf(input logic [31:0] x);
      return x[30:23] == 8'hFF && x[22:0] == 23'd0;
   endfunction
   function automatic bit is_nan(input logic [31:0] x);
      return x[30:23] == 8'hFF && x[22:0] != 23'd0;
   endfunction

   // Stand-in FPU: {flags, result} as a function of the operands
   function automatic logic [39:0] fpu_ref(input logic [31:0] a, b,
                                           input logic [2:0] op);
      logic [7:0]  f;
      logic [31:0] r;
      r = a ^ {b[15:0], b[31:16]} ^ {29'd0, op};
      f[0] = is_inf(a) || is_inf(b);
      f[1] = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
      f[2] = is_nan(a) || is_nan(b)
           || (op == 3'd2 && ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))))
           || (op == 3'd3 && ((is_zero(a) && is_zero(b)) || (is_inf(a) && is_inf(b))));
      f[3] = op != 3'd0 && (a[0] ^ b[0]);
      f[4] = op == 3'd2 && ({1'b0, a[30:23]} + {1'b0, b[30:23]} > 9'd382);
      f[5] = op == 3'd3 && a == 32'h1 && !is_zero(b);
      f[6] = op == 3'd2 && (is_zero(a) || is_zero(b));
      f[7] = op == 3'd3 && is_zero(b) && !is_zero(a) && !is_nan(a) && !is_inf(a);
      return {f, r};
   endfunction

   // FPU pipeline of depth LAT
   always @(posedge clk) begin
      pipe[0] <= fpu_ref(opa, opb, fpu_op);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign fpu_out = pipe[LAT-1][31:0];
   assign {div_by_zero, zero, underflow, overflow, ine, qnan, snan, inf} =
          pipe[LAT-1][39:32];

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic m, input logic [31:0] s);
      start = 1'b1;
      mode  = m;
      seed  = s;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait for record k, check it against the model, then accept it
   task automatic collect(input int k, input bit bp);
      logic [31:0] ea, eb;
      logic [2:0]  eop;
      logic [39:0] r;
      int          n;
      if (run_mode) begin
         exp_lfsr = (exp_lfsr >> 1) ^ (exp_lfsr[0] ? 32'h8020_0003 : 32'h0);
         ea  = exp_lfsr;
         eb  = {exp_lfsr[15:0], exp_lfsr[31:16]};
         eop = {1'b0, exp_lfsr[1:0]};
      end else begin
         ea  = TBL[(k / 8) % 8];
         eb  = TBL[k % 8];
         eop = 3'((k / 64) % 4);
      end
      r = fpu_ref(ea, eb, eop);
      if (bp) rec_ready = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rec_valid && n < 400);
      check("rec_wait", {31'd0, rec_valid}, 32'd1);
      got_opa   = rec_opa;
      got_opb   = rec_opb;
      got_op    = rec_op;
      got_out   = rec_out;
      got_flags = rec_flags;
      check("rec_opa", rec_opa, ea);
      check("rec_opb", rec_opb, eb);
      check("rec_op", {29'd0, rec_op}, {29'd0, eop});
      check("rec_out", rec_out, r[31:0]);
      check("rec_flags", {24'd0, rec_flags}, {24'd0, r[39:32]});
      check("busy_run", {31'd0, busy}, 32'd1);
      check("cnt_pre", {16'd0, vec_count}, 32'(k));
      check("pin_neutral", opa, NEUTRAL);
      if (bp) begin
         repeat (10) begin
            @(negedge clk);
            check("bp_valid", {31'd0, rec_valid}, 32'd1);
            check("bp_opa", rec_opa, got_opa);
            check("bp_out", rec_out, got_out);
            check("bp_flags", {24'd0, rec_flags}, {24'd0, got_flags});
            check("bp_pins", opb, NEUTRAL);
            check("bp_cnt", {16'd0, vec_count}, 32'(k));
         end
         rec_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check("valid_drop", {31'd0, rec_valid}, 32'd0);
      check("cnt_post", {16'd0, vec_count}, 32'(k + 1));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; rec_ready = 1'b1;
      run_mode = 1'b0; exp_lfsr = 32'd1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_opa", opa, NEUTRAL);
      check("rst_opb", opb, NEUTRAL);
      check("rst_op", {29'd0, fpu_op}, 32'd0);
      check("rst_rmode", {30'd0, rmode}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_valid", {31'd0, rec_valid}, 32'd0);
      check("rst_cnt", {16'd0, vec_count}, 32'd0);
      check("rst_recopa", rec_opa, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full corner sweep with backpressure and a start while busy
      run_mode = 1'b0;
      pulse_start(1'b0, 32'd0);
      check("busy_start", {31'd0, busy}, 32'd1);
      for (int k = 0; k < 256; k++) begin
         if (k == 3) pulse_start(1'b1, 32'h1234_5678);
         collect(k, k == 20);
         if (k == 0) begin
            check("r0_opa", got_opa, 32'h0);
            check("r0_op", {29'd0, got_op}, 32'd0);
         end
         if (k == 144) check("r144_qnan", {31'd0, got_flags[2]}, 32'd1);
         if (k == 200) begin
            check("r200_opa", got_opa, 32'h3F80_0000);
            check("r200_opb", got_opb, 32'h0);
            check("r200_op", {29'd0, got_op}, 32'd3);
            check("r200_dbz", {31'd0, got_flags[7]}, 32'd1);
         end
         if (k == 255) begin
            check("r255_opa", got_opa, 32'h7FC0_0000);
            check("r255_opb", got_opb, 32'h7FC0_0000);
            check("r255_op", {29'd0, got_op}, 32'd3);
         end
      end
      @(negedge clk);
      check("sw_done", {31'd0, done}, 32'd1);
      check("sw_busy", {31'd0, busy}, 32'd0);
      check("sw_cnt", {16'd0, vec_count}, 32'd256);

      // Random run from seed 0
      repeat (2) @(negedge clk);
      run_mode = 1'b1;
      exp_lfsr = 32'd1;
      pulse_start(1'b1, 32'd0);
      check("rnd_done_clr", {31'd0, done}, 32'd0);
      for (int k = 0; k < 64; k++) begin
         collect(k, 1'b0);
         if (k == 0) begin
            check("rnd0_opa", got_opa, 32'h8020_0003);
            check("rnd0_opb", got_opb, 32'h0003_8020);
         end
      end
      @(negedge clk);
      check("rnd_done", {31'd0, done}, 32'd1);
      check("rnd_cnt", {16'd0, vec_count}, 32'd64);

      // Reset during WAIT of vector 5, then restart
      repeat (2) @(negedge clk);
      run_mode = 1'b0;
      pulse_start(1'b0, 32'd0);
      for (int k = 0; k < 5; k++) collect(k, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("w5_opa", opa, TBL[0]);
      check("w5_opb", opb, TBL[5]);
      @(posedge clk);
      #1;
      check("w5_hold", opb, TBL[5]);
      rst_n = 1'b0;
      #1;
      check("mr_opa", opa, NEUTRAL);
      check("mr_opb", opb, NEUTRAL);
      check("mr_busy", {31'd0, busy}, 32'd0);
      check("mr_valid", {31'd0, rec_valid}, 32'd0);
      check("mr_cnt", {16'd0, vec_count}, 32'd0);
      check("mr_recopa", rec_opa, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("mr_idle", {31'd0, busy}, 32'd0);
      pulse_start(1'b0, 32'd0);
      collect(0, 1'b0);
      collect(1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
